keypad_event_ctrl: RTL
======================

Name: keypad_event_ctrl

Overview:
Sequences the output of the 4x4 keypad scanner into discrete key events for the calculator core. Detects each new press, encodes the column/row pair into a 4-bit key code, and generates auto-repeat events while a key is held. Events are buffered in a small FIFO behind a valid/ready handshake. Sits between the keypad scanner and the calculator input decoder.

Parameters:
FIFO_DEPTH, 4, event FIFO entries; power of 2, 2..16.
REPEAT_EN, 1, 1 enables auto-repeat while held; 0 gives one event per press.
REPEAT_DELAY, 6000000, clk ticks from first event to first repeat (500 ms @ 12 MHz); range 1..2^24-1.
REPEAT_PERIOD, 1200000, clk ticks between subsequent repeats (100 ms @ 12 MHz); range 1..2^24-1.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
scan_col  in  4  one-hot column currently driven by the scanner
scan_row  in  4  row bits latched by the scanner
scan_pressed  in  1  scanner "key held" flag; high while a key is confirmed held
key_code  out  4  code at FIFO head = row_index*4 + col_index
key_valid  out  1  FIFO non-empty
key_ready  in  1  consumer accepts head when key_valid && key_ready
overflow  out  1  sticky: event dropped because FIFO was full
ghost  out  1  sticky: press rejected because row or col was not one-hot
clear_flags  in  1  clears overflow and ghost for one cycle
fifo_level  out  clog2(FIFO_DEPTH)+1  current entry count

Behaviour:
- Everything synchronous to clk. reset=1 at a clock edge: FIFO empty, key_valid=0, key_code=0, fifo_level=0, overflow=0, ghost=0, FSM=IDLE, repeat counter=0, scan_pressed edge register=0. Reset mid-hold drops the held key; no event until scan_pressed goes low then high again.
- Press detect: press_edge = scan_pressed && !pressed_q (pressed_q is registered scan_pressed). scan_col/scan_row sampled in the edge cycle.
- Encoding: col_index/row_index = position of the set bit (bit0 -> 0). If either vector is not exactly one-hot, no event is produced, ghost<=1 and the FSM stays IDLE until scan_pressed falls.
- FSM states:
  - IDLE: on a valid press_edge, enqueue the code, latch held_code, clear the counter, and go to DELAY if REPEAT_EN=1, otherwise go to HELD.
  - DELAY: count each cycle. When counter reaches REPEAT_DELAY-1, enqueue held_code, clear the counter, and go to REPEAT.
  - REPEAT: count each cycle. When counter reaches REPEAT_PERIOD-1, enqueue held_code and clear the counter.
  - HELD: wait.
  - In DELAY, REPEAT or HELD, scan_pressed=0 returns the FSM to IDLE immediately. An enqueue scheduled in the same cycle as the release is suppressed.
- Latency: a press edge at clock edge N writes the FIFO at edge N. key_valid and key_code reflect it after edge N, provided the FIFO was empty.
- Repeat timing: first repeat is enqueued exactly REPEAT_DELAY cycles after the first event. Each following repeat is REPEAT_PERIOD cycles after the previous one.
- FIFO: synchronous, with registered head. Pop when key_valid && key_ready.
  - Push on full without a pop: the event is dropped and overflow<=1.
  - Push and pop in the same cycle are both performed, even when full; level is unchanged.
  - Pop when empty is ignored. Pointers wrap modulo FIFO_DEPTH.
- Flags: overflow and ghost are sticky. clear_flags clears them, but a set event in the same cycle wins over the clear.
- key_code holds its last head value while key_valid=0; it is not cleared on empty.
- scan_col/scan_row changes while in DELAY, REPEAT or HELD are ignored; held_code is fixed from the press edge.

Test Plan:
1. Reset, REPEAT_EN=0: scan_col=0100, scan_row=0010, scan_pressed 0->1 held 50 cycles, key_ready=1 -> exactly one event with key_code=6, key_valid high for 1 cycle, then no further events.
2. REPEAT_DELAY=10, REPEAT_PERIOD=4, key_ready=1: press col=0001 row=1000 for 30 cycles -> key_code=12 events at cycles 0, 10, 14, 18, 22, 26 relative to the press edge (6 total); release -> no more events.
3. FIFO_DEPTH=4, key_ready=0, REPEAT_EN=0: five separate presses with codes 1,2,3,4,5 -> fifo_level=4, overflow=1; draining with key_ready=1 yields 1,2,3,4; clear_flags -> overflow=0.
4. Ghost: press with scan_row=0110 -> no event, ghost=1. Release, then press row=0001 col=0010 -> key_code=1 event, ghost remains 1 until clear_flags.
5. Full FIFO with key_ready=1 and a new press in the same cycle -> pop and push both occur, fifo_level stays 4, overflow stays 0.
6. Assert reset during DELAY with scan_pressed still 1 -> FIFO empty, no event until scan_pressed drops and rises again; that next press produces an event one cycle after its edge.

Source files
------------

// File: rtl/keypad_event_ctrl.sv
// Turns keypad scanner output into discrete key events with auto-repeat,
// queued in a small FIFO behind a valid/ready handshake.
module keypad_event_ctrl #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 6000000,
  parameter int unsigned REPEAT_PERIOD = 1200000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [3:0]                    scan_col,
  input  logic [3:0]                    scan_row,
  input  logic                          scan_pressed,
  output logic [3:0]                    key_code,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic                          overflow,
  output logic                          ghost,
  input  logic                          clear_flags,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = 24;
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [LVL_W-1:0] LVL_FULL    = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HELD} state_t;

  function automatic logic [1:0] bit_index(input logic [3:0] v);
    bit_index = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (v[k]) bit_index = 2'(k);
    end
  endfunction

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         held_code;
  logic               pressed_q;
  logic               armed;
  logic [3:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  logic               press_edge;
  logic               press_ok;
  logic [3:0]         press_code;
  logic               push_req;
  logic [3:0]         push_data;
  logic               ghost_set;
  logic               do_pop;
  logic               do_push;
  logic               full;
  logic               overflow_set;
  logic [LVL_W-1:0]   level_next;
  logic [3:0]         head_next;

  // Event generation and FIFO next-state decisions
  always_comb begin
    press_edge   = scan_pressed && !pressed_q && armed;
    press_ok     = is_onehot(scan_col) && is_onehot(scan_row);
    press_code   = {bit_index(scan_row), bit_index(scan_col)};
    push_req     = 1'b0;
    push_data    = held_code;
    unique case (state)
      IDLE: begin
        if (press_edge && press_ok) begin
          push_req  = 1'b1;
          push_data = press_code;
        end
      end
      DELAY:   push_req = scan_pressed && (cnt == DELAY_LAST);
      REPEAT:  push_req = scan_pressed && (cnt == PERIOD_LAST);
      default: push_req = 1'b0;
    endcase
    ghost_set    = (state == IDLE) && press_edge && !press_ok;
    do_pop       = key_valid && key_ready;
    full         = (fifo_level == LVL_FULL);
    do_push      = push_req && (!full || do_pop);
    overflow_set = push_req && full && !do_pop;
    level_next   = fifo_level + LVL_W'(do_push) - LVL_W'(do_pop);
    head_next    = key_code;
    if (level_next != LVL_W'(0)) begin
      if (do_pop && (fifo_level > LVL_W'(1))) begin
        head_next = mem[PTR_W'(rd_ptr + PTR_W'(1))];
      end else if (do_pop || (fifo_level == LVL_W'(0))) begin
        head_next = push_data;
      end
    end
  end

  // Press/hold/repeat state machine; armed blocks a press until a release is seen after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      held_code <= 4'd0;
      pressed_q <= 1'b0;
      armed     <= 1'b0;
    end else begin
      pressed_q <= scan_pressed;
      if (!scan_pressed) armed <= 1'b1;
      unique case (state)
        IDLE: begin
          if (press_edge && press_ok) begin
            held_code <= press_code;
            cnt       <= '0;
            state     <= REPEAT_EN ? DELAY : HELD;
          end
        end
        DELAY: begin
          if (!scan_pressed) begin
            state <= IDLE;
          end else if (cnt == DELAY_LAST) begin
            cnt   <= '0;
            state <= REPEAT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (!scan_pressed) begin
            state <= IDLE;
          end else if (cnt == PERIOD_LAST) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          if (!scan_pressed) state <= IDLE;
        end
      endcase
    end
  end

  // FIFO storage, unreset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // FIFO control, registered head and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      key_valid  <= 1'b0;
      key_code   <= 4'd0;
      overflow   <= 1'b0;
      ghost      <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_level <= level_next;
      key_valid  <= (level_next != LVL_W'(0));
      key_code   <= head_next;
      overflow   <= overflow_set | (overflow & ~clear_flags);
      ghost      <= ghost_set | (ghost & ~clear_flags);
    end
  end

endmodule
